sdram_arbiter: RTL and testbench

Two-port request arbiter and refresh scheduler placed directly upstream of the `sdram` byte-address controller. It multiplexes a video port (A) and a CPU port (B) onto the controller's single `rd`/`wr`/`refresh` command interface. It inserts auto-refresh every `REFRESH_CYCLES` clocks and returns read data to the port that issued the read. All command sequencing against the controller's `busy`/`data_ready` handshake is handled here, so clients see a simple req/ack/rvalid protocol.

---
 rtl/sdram_arbiter_pkg.sv | 15 +
 rtl/sdram_refresh_timer.sv | 25 ++
 rtl/sdram_arbiter.sv | 106 ++++++++++
 tb/tb_sdram_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arbiter_pkg.sv
// sdram_arbiter_pkg: shared types for the two-port SDRAM arbiter
package sdram_arbiter_pkg;
    localparam int ADDR_WIDTH = 23;

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_ISSUE, S_SETTLE, S_WAIT} state_t;

    typedef enum logic [1:0] {OWN_A, OWN_B, OWN_REF} owner_t;

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [31:0]           wdata;
        logic [3:0]            wdm;
    } port_req_t;
endpackage

// File: rtl/sdram_refresh_timer.sv
// sdram_refresh_timer: wrapping refresh interval counter with a sticky pending flag
module sdram_refresh_timer #(
    parameter int REFRESH_CYCLES = 810
) (
    input  logic clk,
    input  logic resetn,
    input  logic hold,
    input  logic clear,
    output logic pending
);
    localparam int CW = $clog2(REFRESH_CYCLES + 1);
    logic [CW-1:0] cnt;
    logic wrap;
    assign wrap = cnt == CW'(REFRESH_CYCLES - 1);
    always_ff @(posedge clk) begin
        if (!resetn || hold) cnt <= '0;
        else cnt <= wrap ? '0 : cnt + 1'b1;
    end
    // a wrap that coincides with a clear still marks a new refresh as due
    always_ff @(posedge clk) begin
        if (!resetn) pending <= 1'b0;
        else if (wrap && !hold) pending <= 1'b1;
        else if (clear) pending <= 1'b0;
    end
endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: round-robin video/CPU arbiter with refresh insertion in front of the sdram controller
module sdram_arbiter #(
    parameter int REFRESH_CYCLES = 810,
    parameter int ADDR_WIDTH     = sdram_arbiter_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [31:0]           a_wdata,
    input  logic [3:0]            a_wdm,
    output logic                  a_ack,
    output logic [31:0]           a_rdata,
    output logic                  a_rvalid,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [31:0]           b_wdata,
    input  logic [3:0]            b_wdm,
    output logic                  b_ack,
    output logic [31:0]           b_rdata,
    output logic                  b_rvalid,
    output logic                  sd_rd,
    output logic                  sd_wr,
    output logic                  sd_refresh,
    output logic [ADDR_WIDTH-1:0] sd_addr,
    output logic [31:0]           sd_din32,
    output logic [3:0]            sd_wdm,
    input  logic [31:0]           sd_dout32,
    input  logic                  sd_data_ready,
    input  logic                  sd_busy,
    input  logic                  sd_enabled
);
    import sdram_arbiter_pkg::*;

    state_t    state, state_nx;
    owner_t    owner;
    port_req_t sel;
    logic      pending, last_b, idle, in_init, gnt_a, gnt_b, gnt_ref, gnt_port;

    assign in_init = state == S_INIT;

    sdram_refresh_timer #(.REFRESH_CYCLES(REFRESH_CYCLES)) u_timer (
        .clk(clk),
        .resetn(resetn),
        .hold(in_init),
        .clear(gnt_ref),
        .pending(pending)
    );

    always_ff @(posedge clk) state <= !resetn ? S_INIT : state_nx;

    // SETTLE exists because busy still reflects the previous command for one cycle
    always_comb begin
        state_nx = state;
        case (state)
            S_INIT:   state_nx = (sd_enabled && !sd_busy) ? S_IDLE : S_INIT;
            S_IDLE:   state_nx = (gnt_ref || gnt_port) ? S_ISSUE : S_IDLE;
            S_ISSUE:  state_nx = S_SETTLE;
            S_SETTLE: state_nx = S_WAIT;
            S_WAIT:   state_nx = sd_busy ? S_WAIT : S_IDLE;
            default:  state_nx = S_INIT;
        endcase
    end

    always_comb begin
        idle     = state == S_IDLE;
        gnt_ref  = idle && pending;
        gnt_a    = idle && !pending && a_req && (!b_req || last_b);
        gnt_b    = idle && !pending && b_req && (!a_req || !last_b);
        gnt_port = gnt_a || gnt_b;
        sel      = gnt_a ? {a_we, a_addr, a_wdata, a_wdm} : {b_we, b_addr, b_wdata, b_wdm};
    end

    // sd_addr/din/wdm stay put between grants: the controller re-samples at column time
    always_ff @(posedge clk) begin
        if (!resetn) begin
            {a_ack, b_ack, a_rvalid, b_rvalid, sd_rd, sd_wr, sd_refresh} <= '0;
            a_rdata  <= '0;
            b_rdata  <= '0;
            sd_addr  <= '0;
            sd_din32 <= '0;
            sd_wdm   <= '0;
            owner    <= OWN_REF;
            last_b   <= 1'b1;
        end else begin
            a_ack      <= gnt_a;
            b_ack      <= gnt_b;
            sd_rd      <= gnt_port && !sel.we;
            sd_wr      <= gnt_port && sel.we;
            sd_refresh <= gnt_ref;
            a_rvalid   <= sd_data_ready && owner == OWN_A;
            b_rvalid   <= sd_data_ready && owner == OWN_B;
            if (sd_data_ready && owner == OWN_A) a_rdata <= sd_dout32;
            if (sd_data_ready && owner == OWN_B) b_rdata <= sd_dout32;
            if (gnt_port) begin
                sd_addr  <= sel.addr;
                sd_din32 <= sel.wdata;
                sd_wdm   <= sel.wdm;
                last_b   <= gnt_b;
            end
            if (gnt_ref || gnt_port) owner <= gnt_ref ? OWN_REF : gnt_a ? OWN_A : OWN_B;
        end
    end
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: controller model, transaction-level arbitration model, directed and random stimulus
module tb_sdram_arbiter;
    localparam int R = 810;

    logic clk = 0, resetn = 0;
    logic a_req = 0, b_req = 0, a_we = 0, b_we = 0;
    logic [22:0] a_addr = '0, b_addr = '0, sd_addr;
    logic [31:0] a_wdata = '0, b_wdata = '0, a_rdata, b_rdata, sd_din32, sd_dout32 = '0;
    logic [3:0] a_wdm = '0, b_wdm = '0, sd_wdm;
    logic a_ack, b_ack, a_rvalid, b_rvalid, sd_rd, sd_wr, sd_refresh;
    logic sd_data_ready = 0, sd_busy = 0, sd_enabled = 0;
    int checks = 0, errors = 0, n = 0;

    sdram_arbiter dut (
        .clk(clk), .resetn(resetn),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_wdm(a_wdm),
        .a_ack(a_ack), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_wdm(b_wdm),
        .b_ack(b_ack), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
        .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_refresh(sd_refresh),
        .sd_addr(sd_addr), .sd_din32(sd_din32), .sd_wdm(sd_wdm),
        .sd_dout32(sd_dout32), .sd_data_ready(sd_data_ready),
        .sd_busy(sd_busy), .sd_enabled(sd_enabled)
    );

    always #5 clk = ~clk;
    always @(posedge clk) n++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h want %0h", name, n, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_fn(input logic [22:0] a);
        return 32'hDEADBEEF ^ ((32'(a) ^ 32'h104) * 32'h9E3779B1);
    endfunction

    // controller model: busy until base+stretch cycles after the command, read strobe 4 cycles after
    int ct = -1, busy_end = 0, dr_at = -1, cur_stretch = 0, force_stretch = -1;
    bit rand_stretch = 0;
    logic [22:0] ctl_addr = '0;
    always @(posedge clk) begin
        #1;
        sd_data_ready = 0;
        if (!resetn) begin
            ct = -1;
            sd_busy = 0;
        end else if (sd_rd || sd_wr || sd_refresh) begin
            cur_stretch = force_stretch >= 0 ? force_stretch : rand_stretch ? int'($urandom_range(0, 3)) : 0;
            ct = 0;
            sd_busy = 1;
            busy_end = (sd_refresh ? 4 : 5) + cur_stretch;
            dr_at = sd_rd ? 4 : -1;
            ctl_addr = sd_addr;
        end else if (ct >= 0) begin
            ct++;
            if (ct == dr_at) begin
                sd_data_ready = 1;
                sd_dout32 = rd_fn(ctl_addr);
            end
            if (ct == busy_end) begin
                sd_busy = 0;
                ct = -1;
            end
        end
    end

    // transaction-level model: who must be granted at each edge, and when read data must return
    bit in_init = 1, last_b = 1, rv_b = 0;
    int e0 = 0, free = 0, last_wrap = -2, last_ref = -1, rv_edge = -1, first_ref = -1;
    logic [31:0] rv_data = '0, exp_ard = '0, exp_brd = '0;
    logic p_rst = 0, p_en = 0, p_busy = 0, pa = 0, pb = 0, pa_we = 0, pb_we = 0;
    logic [22:0] pa_addr = '0, pb_addr = '0;
    logic [31:0] pa_wd = '0, pb_wd = '0;
    logic [3:0] pa_m = '0, pb_m = '0;
    always @(negedge clk) begin
        bit pend, wrap, er, ea, eb, can, win_b;
        if (sd_refresh && first_ref < 0) first_ref = n;
        if (!p_rst) begin
            chk("rst_ctl", {a_ack, b_ack, a_rvalid, b_rvalid, sd_rd, sd_wr, sd_refresh}, 0);
            chk("rst_rdata", a_rdata | b_rdata, 0);
            chk("rst_sd_bus", sd_din32 | 32'(sd_addr) | 32'(sd_wdm), 0);
            in_init = 1; last_b = 1; last_wrap = -2; last_ref = -1; rv_edge = -1;
            exp_ard = 0; exp_brd = 0;
        end else begin
            pend = !in_init && last_wrap >= last_ref;
            wrap = !in_init && n > e0 && (n - e0) % R == 0;
            can = !in_init && n >= free;
            win_b = (pa && pb) ? !last_b : pb;
            er = can && pend;
            ea = can && !pend && (pa || pb) && !win_b;
            eb = can && !pend && (pa || pb) && win_b;
            chk("sd_refresh", sd_refresh, er);
            chk("a_ack", a_ack, ea);
            chk("b_ack", b_ack, eb);
            chk("sd_rd", sd_rd, (ea && !pa_we) || (eb && !pb_we));
            chk("sd_wr", sd_wr, (ea && pa_we) || (eb && pb_we));
            if (ea || eb) begin
                chk("sd_addr", sd_addr, eb ? pb_addr : pa_addr);
                chk("sd_din32", sd_din32, eb ? pb_wd : pa_wd);
                chk("sd_wdm", sd_wdm, eb ? pb_m : pa_m);
                last_b = eb;
                free = n + 5 + cur_stretch + 2;
                if (!(eb ? pb_we : pa_we)) begin
                    rv_edge = n + 5;
                    rv_b = eb;
                    rv_data = rd_fn(eb ? pb_addr : pa_addr);
                end
            end
            if (er) begin
                free = n + 4 + cur_stretch + 2;
                last_ref = n;
            end
            if (wrap) last_wrap = n;
            if (rv_edge == n && !rv_b) exp_ard = rv_data;
            if (rv_edge == n && rv_b) exp_brd = rv_data;
            chk("a_rvalid", a_rvalid, rv_edge == n && !rv_b);
            chk("b_rvalid", b_rvalid, rv_edge == n && rv_b);
            chk("a_rdata", a_rdata, exp_ard);
            chk("b_rdata", b_rdata, exp_brd);
            if (in_init && p_en && !p_busy) begin
                in_init = 0;
                e0 = n;
                free = n + 1;
            end
        end
        p_rst = resetn; p_en = sd_enabled; p_busy = sd_busy;
        pa = a_req; pa_we = a_we; pa_addr = a_addr; pa_wd = a_wdata; pa_m = a_wdm;
        pb = b_req; pb_we = b_we; pb_addr = b_addr; pb_wd = b_wdata; pb_m = b_wdm;
    end

    task automatic wait_ack(input int which, output int g);
        g = -1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if ((which != 1 && a_ack) || (which != 0 && b_ack)) begin
                g = n;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL ack_timeout: port %0d got no ack within 100 cycles", which);
    endtask

    task automatic rand_a();
        a_addr = 23'($urandom); a_wdata = $urandom; a_wdm = 4'($urandom);
    endtask

    task automatic rand_b();
        b_addr = 23'($urandom); b_wdata = $urandom; b_wdm = 4'($urandom);
    endtask

    typedef struct packed {bit a, b, awe, bwe, ack_a, ack_b, rd, wr;} vec_t;
    vec_t tbl[10];

    initial begin
        int g, g2, n0, prev, pg, refs;
        bit rseen, cur;
        logic [22:0] addr_c;
        // a b awe bwe | ack_a ack_b rd wr ; A was granted last before entry 0
        tbl = '{8'b1110_0110, 8'b1101_1010, 8'b1010_1001, 8'b1101_0101, 8'b0100_0110,
                8'b1111_1001, 8'b0101_0101, 8'b1100_1010, 8'b1111_0101, 8'b1000_1010};
        repeat (3) @(posedge clk);
        #1 resetn = 1;
        repeat (30) @(posedge clk);
        #1 sd_enabled = 1;
        repeat (3) @(posedge clk);
        #1 a_req = 1; a_we = 0; a_addr = 23'h000104;
        wait_ack(0, g);
        chk("dir_sd_addr", sd_addr, 23'h000104);
        chk("dir_sd_rd", sd_rd, 1);
        a_req = 0;
        repeat (5) @(posedge clk); #1;
        chk("dir_a_rvalid", a_rvalid, 1);
        chk("dir_a_rdata", a_rdata, 32'hDEADBEEF);
        chk("dir_b_rvalid", b_rvalid, 0);

        foreach (tbl[i]) begin
            repeat (12) @(posedge clk); #1;
            {a_req, b_req, a_we, b_we} = {tbl[i].a, tbl[i].b, tbl[i].awe, tbl[i].bwe};
            rand_a(); rand_b();
            n0 = n;
            wait_ack(2, g);
            chk($sformatf("tbl%0d_ack_a", i), a_ack, tbl[i].ack_a);
            chk($sformatf("tbl%0d_ack_b", i), b_ack, tbl[i].ack_b);
            chk($sformatf("tbl%0d_rd", i), sd_rd, tbl[i].rd);
            chk($sformatf("tbl%0d_wr", i), sd_wr, tbl[i].wr);
            chk($sformatf("tbl%0d_latency", i), g - n0, 1);
            a_req = 0; b_req = 0;
        end

        for (int i = 0; i < 1200 && first_ref < 0; i++) @(posedge clk);
        chk("first_refresh_after_enable", first_ref - e0, R + 1);

        repeat (12) @(posedge clk); #1;
        a_req = 1; b_req = 1; a_we = 1; b_we = 1; rand_a(); rand_b();
        prev = -1; pg = 0; refs = 0; rseen = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (sd_refresh) begin refs++; rseen = 1; end
            if (a_ack || b_ack) begin
                cur = b_ack;
                chk("alt_wdm", sd_wdm, cur ? b_wdm : a_wdm);
                chk("alt_din", sd_din32, cur ? b_wdata : a_wdata);
                if (prev >= 0) begin
                    chk("alt_port", cur, !prev[0]);
                    chk("alt_gap", n - pg, rseen ? 13 : 7);
                end
                prev = cur; pg = n; rseen = 0;
                if (cur) rand_b(); else rand_a();
            end
        end
        chk("alt_refresh_seen", refs > 0, 1);
        a_req = 0; b_req = 0;

        repeat (15) @(posedge clk); #1;
        force_stretch = 20;
        a_req = 1; a_we = 1; rand_a();
        wait_ack(0, g);
        addr_c = a_addr;
        a_req = 0; b_req = 1; b_we = 0; rand_b();
        repeat (3) @(posedge clk);
        #1 force_stretch = -1;
        g2 = -1;
        for (int i = 0; i < 40 && g2 < 0; i++) begin
            @(posedge clk); #1;
            if (b_ack) g2 = n;
            else chk("stretch_addr_stable", sd_addr, addr_c);
        end
        chk("stretch_next_grant", g2 - g, 27);
        b_req = 0;

        repeat (12) @(posedge clk); #1;
        a_req = 1; a_we = 0; rand_a();
        wait_ack(0, g);
        a_req = 0;
        repeat (2) @(posedge clk);
        #1 resetn = 0;
        @(posedge clk); #1;
        chk("midrst_ctl", {a_ack, b_ack, a_rvalid, b_rvalid, sd_rd, sd_wr, sd_refresh}, 0);
        chk("midrst_rdata", a_rdata | b_rdata, 0);
        chk("midrst_bus", sd_din32 | 32'(sd_addr) | 32'(sd_wdm), 0);
        sd_enabled = 0;
        @(posedge clk);
        #1 resetn = 1; a_req = 1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("midrst_no_rvalid", a_rvalid | b_rvalid, 0);
            chk("init_no_ack", a_ack, 0);
        end
        sd_enabled = 1;
        wait_ack(0, g);
        a_req = 0;

        rand_stretch = 1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (a_ack) a_req = 0;
            if (b_ack) b_req = 0;
            if (!a_req && $urandom_range(0, 2) == 0) begin a_req = 1; a_we = 1'($urandom); rand_a(); end
            if (!b_req && $urandom_range(0, 2) == 0) begin b_req = 1; b_we = 1'($urandom); rand_b(); end
        end
        a_req = 0; b_req = 0;
        repeat (20) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
